// File: rtl/systolic_output_drain.sv
// systolic_output_drain: snapshots an accumulator tile and streams it out row by row, requantized to OUT_W lanes
module systolic_output_drain #(
   parameter int N_ROWS = 8,
   parameter int N_COLS = 8,
   parameter int ACC_W  = 32,
   parameter int OUT_W  = 8,
   localparam int RW    = N_ROWS > 1 ? $clog2(N_ROWS) : 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             capture,
   input  logic [N_ROWS*N_COLS*ACC_W-1:0]   c_in_flat,
   input  logic [4:0]                       shift,
   input  logic                             relu_en,
   input  logic                             out_ready,
   output logic                             out_valid,
   output logic [N_COLS*OUT_W-1:0]          out_data,
   output logic [RW-1:0]                    out_row,
   output logic                             out_last,
   output logic                             busy,
   output logic                             sat_flag
);
   typedef enum logic {IDLE, DRAIN} state_t;
   localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(2**(OUT_W-1) - 1);
   localparam logic signed [ACC_W:0] MINV = -MAXV - 1;
   state_t                         state;
   logic [RW-1:0]                  row;
   logic [N_ROWS*N_COLS*ACC_W-1:0] snap;
   logic [4:0]                     shift_r;
   logic                           relu_r;
   logic [ACC_W:0]                 rnd;
   logic [N_COLS*OUT_W-1:0]        lanes;
   logic [N_COLS-1:0]              lane_sat;
   logic                           drain, last_row, xfer, accept;
   assign drain     = state == DRAIN;
   assign last_row  = row == RW'(N_ROWS - 1);
   assign xfer      = drain && out_ready;
   // a new tile is taken when idle, or back-to-back on the final beat so the stream has no bubble
   assign accept    = capture && (!drain || (xfer && last_row));
   assign rnd       = shift_r == 5'd0 ? '0 : (ACC_W+1)'(1) << (shift_r - 5'd1);
   assign out_valid = drain;
   assign busy      = drain;
   assign out_row   = row;
   assign out_last  = drain && last_row;
   assign out_data  = drain ? lanes : '0;
   for (genvar c = 0; c < N_COLS; c++) begin : g_lane
      logic [ACC_W-1:0]        acc;
      logic signed [ACC_W:0]   sum, sh, t;
      logic                    hi, lo;
      assign acc = snap[(int'(row)*N_COLS + c)*ACC_W +: ACC_W];
      assign sum = {acc[ACC_W-1], acc} + rnd;
      assign sh  = sum >>> shift_r;
      assign t   = (relu_r && sh[ACC_W]) ? '0 : sh;
      assign hi  = t > MAXV;
      assign lo  = t < MINV;
      assign lane_sat[c] = hi || lo;
      assign lanes[c*OUT_W +: OUT_W] = hi ? MAXV[OUT_W-1:0] : lo ? MINV[OUT_W-1:0] : t[OUT_W-1:0];
   end
   // snapshot storage needs no reset: out_data is masked to zero outside DRAIN
   always_ff @(posedge clk) begin
      if (accept) snap <= c_in_flat;
   end
   // drain FSM: row pointer, latched requant settings and sticky saturation flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         row      <= '0;
         shift_r  <= '0;
         relu_r   <= 1'b0;
         sat_flag <= 1'b0;
      end else if (accept) begin
         state    <= DRAIN;
         row      <= '0;
         shift_r  <= shift;
         relu_r   <= relu_en;
         sat_flag <= 1'b0;
      end else if (xfer) begin
         state    <= last_row ? IDLE : DRAIN;
         row      <= last_row ? '0 : row + RW'(1);
         sat_flag <= sat_flag || (|lane_sat);
      end
   end
endmodule

// File: tb/tb_systolic_output_drain.sv
// tb_systolic_output_drain: scoreboard bench for the tile drain with directed hand-computed vectors
module tb_systolic_output_drain;
   typedef struct packed {
      logic [63:0] d;
      logic [2:0]  r;
      logic        l;
   } beat_t;
   logic          clk = 1'b0;
   logic          rst_n, capture, relu_en, out_ready;
   logic [2047:0] c_in_flat;
   logic [4:0]    shift;
   logic          out_valid, out_last, busy, sat_flag;
   logic [63:0]   out_data;
   logic [2:0]    out_row;
   beat_t         q[$];
   int            compared = 0;
   int            mismatched = 0;
   systolic_output_drain dut (
      .clk(clk), .rst_n(rst_n), .capture(capture), .c_in_flat(c_in_flat),
      .shift(shift), .relu_en(relu_en), .out_ready(out_ready),
      .out_valid(out_valid), .out_data(out_data), .out_row(out_row),
      .out_last(out_last), .busy(busy), .sat_flag(sat_flag)
   );
   always #5 clk = ~clk;
   // monitor: every presented and accepted beat is checked against the next expected beat
   always @(negedge clk) begin
      beat_t e;
      if (rst_n && out_valid && out_ready) begin
         compared++;
         if (q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_beat: row=%0d data=%h, required no beat", out_row, out_data);
         end else begin
            e = q.pop_front();
            if ({out_data, out_row, out_last} !== {e.d, e.r, e.l}) begin
               mismatched++;
               $display("FAIL beat: got data=%h row=%0d last=%b, required data=%h row=%0d last=%b",
                        out_data, out_row, out_last, e.d, e.r, e.l);
            end
         end
      end
   end
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, required %h", n, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic do_capture();
      capture = 1'b1;
      step();
      capture = 1'b0;
   endtask
   task automatic set_all(input int v);
      for (int i = 0; i < 64; i++) c_in_flat[i*32 +: 32] = 32'(v);
   endtask
   task automatic push_rows(input logic [63:0] d);
      for (int r = 0; r < 8; r++) q.push_back('{d: d, r: 3'(r), l: r == 7});
   endtask
   task automatic wait_idle(input string n);
      int k = 0;
      while (busy && k < 100) begin
         step();
         k++;
      end
      chk({n, "_done"}, 64'(busy), 64'd0);
      chk({n, "_queue_empty"}, 64'(q.size()), 64'd0);
   endtask
   initial begin
      rst_n = 1'b0; capture = 1'b0; relu_en = 1'b0; out_ready = 1'b1; shift = 5'd0;
      c_in_flat = '0;
      #3;
      chk("reset_outputs", {out_data, 5'd0, out_row, out_valid, busy, out_last, sat_flag}, 64'd0);
      chk("reset_data", out_data, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      // basic drain: all 16, shift 0
      set_all(16);
      push_rows({8{8'h10}});
      do_capture();
      chk("first_beat_latency", {out_valid, busy, 5'd0, out_row}, {1'b1, 1'b1, 8'd0});
      wait_idle("basic");
      chk("basic_sat", 64'(sat_flag), 64'd0);
      chk("idle_valid", 64'(out_valid), 64'd0);
      chk("idle_data_zero", out_data, 64'd0);
      // rounding and saturation: +5,-5,+300,-300 with shift 1
      for (int i = 0; i < 64; i++)
         c_in_flat[i*32 +: 32] = (i % 4 == 0) ? 32'sd5 : (i % 4 == 1) ? -32'sd5 :
                                 (i % 4 == 2) ? 32'sd300 : -32'sd300;
      shift = 5'd1;
      push_rows({2{8'h80, 8'h7F, 8'hFE, 8'h03}});
      do_capture();
      wait_idle("round");
      chk("round_sat_set", 64'(sat_flag), 64'd1);
      // negative values without and with ReLU
      set_all(-48);
      shift = 5'd0;
      push_rows({8{8'hD0}});
      do_capture();
      chk("sat_cleared_by_capture", 64'(sat_flag), 64'd0);
      wait_idle("neg");
      relu_en = 1'b1;
      push_rows({8{8'h00}});
      do_capture();
      wait_idle("relu");
      chk("relu_no_sat", 64'(sat_flag), 64'd0);
      relu_en = 1'b0;
      // backpressure on row 2, input changed mid-drain
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) c_in_flat[(r*8+c)*32 +: 32] = 32'(r*16 + c);
      shift = 5'd4;
      for (int r = 0; r < 8; r++) q.push_back('{d: {8{8'(r)}}, r: 3'(r), l: r == 7});
      do_capture();
      step();
      step();
      out_ready = 1'b0;
      set_all(99);
      shift = 5'd0;
      relu_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_data", out_data, {8{8'd2}});
         chk("stall_row_valid", {out_valid, out_last, 3'd0, out_row}, {2'b10, 6'd2});
      end
      out_ready = 1'b1;
      relu_en = 1'b0;
      wait_idle("backpressure");
      // capture timing: ignored mid-drain, accepted on the final transfer
      set_all(16);
      shift = 5'd0;
      push_rows({8{8'h10}});
      do_capture();
      repeat (4) step();
      set_all(50);
      capture = 1'b1;
      step();
      capture = 1'b0;
      repeat (2) step();
      chk("at_last_row", {out_last, 4'd0, out_row}, {1'b1, 7'd7});
      set_all(33);
      shift = 5'd1;
      push_rows({8{8'h11}});
      capture = 1'b1;
      step();
      capture = 1'b0;
      chk("back_to_back", {out_valid, 4'd0, out_row}, {1'b1, 7'd0});
      wait_idle("b2b");
      // reset in the middle of a drain
      set_all(16);
      shift = 5'd0;
      push_rows({8{8'h10}});
      do_capture();
      repeat (3) step();
      #1 rst_n = 1'b0;
      #1;
      chk("async_reset_ctrl", {out_valid, busy, out_last, sat_flag, 1'b0, out_row}, 64'd0);
      chk("async_reset_data", out_data, 64'd0);
      q.delete();
      step();
      rst_n = 1'b1;
      repeat (10) step();
      chk("post_reset_idle", {out_valid, busy}, 64'd0);
      push_rows({8{8'h10}});
      do_capture();
      wait_idle("after_reset");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
